// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - Shared select codes, load funct3 codes and FSM encoding for wb_ctrl.
package wb_pkg;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_PC4 = 2'b01;
    localparam logic [1:0] WB_ALU = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_MEM_REQ  = 2'b01,
        S_MEM_WAIT = 2'b10,
        S_WRITE    = 2'b11
    } wb_state_e;

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - Combinational load data lane select and sign/zero extension.
module load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [31:0]     data,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data[7:0];
        case (addr)
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            2'd3:    byte_sel = data[31:24];
            default: byte_sel = data[7:0];
        endcase
        half_sel = addr[1] ? data[31:16] : data[15:0];

        ext = '0;
        case (funct3)
            F3_LB:   ext = XLEN'($signed(byte_sel));
            F3_LH:   ext = XLEN'($signed(half_sel));
            F3_LW:   ext = XLEN'($signed(data));
            F3_LBU:  ext = XLEN'(byte_sel);
            F3_LHU:  ext = XLEN'(half_sel);
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - Multi-cycle write-back controller with load sequencing.
// Optional memory-response watchdog enabled by macro WB_TIMEOUT_EN.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sel,
    input  logic [4:0]      in_rd,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_imm,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_done,
    output logic            wb_err
);

    wb_state_e       state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] ld_q, ld_d;
    logic [XLEN-1:0] ld_ext;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 256) ? 8 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3 (funct3_q),
        .addr   (alu_q[1:0]),
        .data   (mem_resp_data),
        .ext    (ld_ext)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        pc_d     = pc_q;
        alu_d    = alu_q;
        imm_d    = imm_q;
        ld_d     = ld_q;
`ifdef WB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    sel_d    = in_sel;
                    rd_d     = in_rd;
                    funct3_d = in_funct3;
                    pc_d     = in_pc;
                    alu_d    = in_alu;
                    imm_d    = in_imm;
                    state_d  = (in_sel == WB_MEM) ? S_MEM_REQ : S_WRITE;
                end
            end
            S_MEM_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_MEM_WAIT;
`ifdef WB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_MEM_WAIT: begin
                // A response in the limit cycle still wins over the watchdog.
                if (mem_resp_valid) begin
                    ld_d    = ld_ext;
                    state_d = S_WRITE;
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt_q == CNT_LIMIT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sel_q    <= WB_MEM;
            rd_q     <= '0;
            funct3_q <= '0;
            pc_q     <= '0;
            alu_q    <= '0;
            imm_q    <= '0;
            ld_q     <= '0;
`ifdef WB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            pc_q     <= pc_d;
            alu_q    <= alu_d;
            imm_q    <= imm_d;
            ld_q     <= ld_d;
`ifdef WB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign in_ready      = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_MEM_REQ);
    assign mem_req_addr  = mem_req_valid ? {alu_q[XLEN-1:2], 2'b00} : '0;
    assign rf_we         = (state_q == S_WRITE) && (rd_q != 5'd0);
    assign rf_waddr      = rd_q;

    always_comb begin
        case (sel_q)
            WB_MEM:  rf_wdata = ld_q;
            WB_PC4:  rf_wdata = pc_q + XLEN'(4);
            WB_ALU:  rf_wdata = alu_q;
            default: rf_wdata = imm_q;
        endcase
    end

`ifdef WB_TIMEOUT_EN
    assign wb_done = (state_q == S_WRITE) || err_q;
    assign wb_err  = err_q;
`else
    assign wb_done = (state_q == S_WRITE);
    assign wb_err  = 1'b0;
`endif

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Multi-cycle write-back controller for the NPC core. It accepts one decoded write-back request per instruction, using a 2-bit select code that comes from the opcode decoder. For loads, it sequences a memory read over a valid/ready handshake and sign- or zero-extends the returned data. It then drives the single register-file write port, so the rest of the pipeline sees one write per instruction and a done pulse.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `TIMEOUT_CYC`, 255: memory-response watchdog limit, in cycles. Used only with `WB_TIMEOUT_EN`.

Ports:
- `clk`  in  1: the only clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: a write-back request is present.
- `in_ready`  out  1: controller can accept a request; high only in IDLE.
- `in_sel`  in  2: result source. 00 memory data, 01 pc+4, 10 ALU result, 11 extended immediate.
- `in_rd`  in  5: destination register.
- `in_funct3`  in  3: load type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- `in_pc`  in  XLEN: instruction PC.
- `in_alu`  in  XLEN: ALU result; this is the load address when `in_sel`=00.
- `in_imm`  in  XLEN: extended immediate.
- `mem_req_valid`  out  1: load request valid.
- `mem_req_ready`  in  1: memory accepts the request.
- `mem_req_addr`  out  XLEN: word-aligned load address.
- `mem_resp_valid`  in  1: read data valid.
- `mem_resp_data`  in  32: read data word.
- `rf_we`  out  1: register-file write enable.
- `rf_waddr`  out  5: register-file write address.
- `rf_wdata`  out  XLEN: register-file write data.
- `wb_done`  out  1: one-cycle pulse when the request retires.
- `wb_err`  out  1: one-cycle pulse on memory timeout. Tied to 0 without `WB_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, MEM_REQ, MEM_WAIT, WRITE.
- Accept: a request is accepted when `in_valid & in_ready`. On accept, latch sel, rd, funct3, pc, alu and imm.
- Non-load accept (sel≠00): IDLE → WRITE.
  - sel 01 writes pc+4, with modulo-2^XLEN wrap.
  - sel 10 writes the ALU result.
  - sel 11 writes the immediate.
- Load accept (sel=00): IDLE → MEM_REQ.
- MEM_REQ:
  - `mem_req_valid`=1 and `mem_req_addr`={alu[XLEN-1:2],2'b00}.
  - Stays in MEM_REQ until `mem_req_ready`, then → MEM_WAIT.
  - Address and valid are held stable while waiting.
- MEM_WAIT:
  - On `mem_resp_valid`, latch the extended data, then → WRITE.
  - `mem_resp_valid` outside MEM_WAIT is ignored. Memory must not respond in the cycle its request is accepted.
- Load extension, selected by funct3 and alu[1:0]:
  - lb/lbu: select byte alu[1:0].
  - lh/lhu: select halfword alu[1].
  - lw: whole word; alu[1:0] ignored.
  - Sign-extend for lb/lh; zero-extend for lbu/lhu.
  - funct3 011, 110 or 111: data is 0.
- WRITE:
  - `rf_we`=1 unless rd=0; x0 is never written.
  - `wb_done`=1 regardless of rd.
  - Then → IDLE.
- Reset asserted mid-operation: return to IDLE at once. Any pending memory request is abandoned, and a late response is ignored.

## Timing
- Reset values: state IDLE, `in_ready`=1, all other outputs 0.
- All outputs are registered or decoded from state alone; there is no combinational path from inputs to outputs.
- Non-load: accepted in cycle N, `rf_we`/`wb_done` in N+1, `in_ready` high again in N+2. Throughput is one request per 2 cycles.
- Load: accepted in cycle N, `mem_req_valid` from N+1.
  - Request handshake in cycle R, response in cycle S with S>R.
  - Write in S+1, `in_ready` high in S+2.
  - Minimum latency from accept to write is 3 cycles.

## Configuration
- Macro `WB_TIMEOUT_EN`, defined:
  - An 8+-bit counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without a response.
  - When the count reaches `TIMEOUT_CYC`, the next state is IDLE and `wb_done`=1 and `wb_err`=1 pulse in that transition cycle. No register write occurs.
  - A response arriving in the same cycle as the limit wins: the write proceeds normally.
- Macro undefined: MEM_WAIT waits indefinitely, there is no counter, and `wb_err` is constant 0.

## Structure
- Package `wb_pkg` holds:
  - sel codes `WB_MEM`, `WB_PC4`, `WB_ALU`, `WB_IMM`;
  - funct3 load codes;
  - the FSM state encoding.
- Sub-module `load_ext` is combinational (funct3, addr[1:0], data in → XLEN out). It is instantiated once, on the response path.

## Test plan
- ALU write: sel=10, rd=5, alu=0x1234 → `rf_we`=1, waddr=5, wdata=0x1234 one cycle after accept; `wb_done` pulses.
- x0 suppression: sel=11, rd=0, imm=0xFFFFF000 → `rf_we`=0, `wb_done`=1.
- pc+4 wrap: sel=01, pc=0xFFFFFFFC, rd=1 → wdata=0x00000000.
- lb with backpressure: alu=0x80000003, `mem_req_ready` low for 3 cycles, data=0x80FFFFFF → addr=0x80000000 held stable, wdata=0xFFFFFF80.
- lhu and invalid funct3: alu=0x2, data=0xBEEF0000 gives 0x0000BEEF; funct3=111 gives 0.
- Timeout and reset (`WB_TIMEOUT_EN` defined, `TIMEOUT_CYC`=4): no response → `wb_err` pulse, no write. `rst_n` low during MEM_REQ → IDLE, `mem_req_valid`=0, a later response is ignored.
